ram_bus_arbiter: RTL and testbench

//  Shares the single RAM port between CPUS cores' icache and dcache requesters.

---
 rtl/cpu_types_pkg.sv | 7 +
 rtl/rr_picker.sv | 21 ++
 rtl/ram_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU/RAM types and arbiter constants
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;
  localparam int BURST_WORDS = 2;
endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin priority encoder
module rr_picker #(
  parameter int N  = 2,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [PW-1:0] idx_o,
  output logic          vld_o
);
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        vld_o = 1'b1;
        idx_o = PW'((int'(ptr_i) + k) % N);
      end
    end
  end
endmodule

// File: rtl/ram_bus_arbiter.sv
// rtl/ram_bus_arbiter.sv - shares one RAM port among per-core icache/dcache requesters
module ram_bus_arbiter
  import cpu_types_pkg::*;
#(
  parameter int CPUS  = 2,
  parameter int BURST = BURST_WORDS,
  localparam int IDW  = $clog2(2*CPUS),
  localparam int PW   = (CPUS > 1) ? $clog2(CPUS) : 1,
  localparam int BW   = $clog2(BURST) + 1
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS*32-1:0] iaddr,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  input  ramstate_t          ramstate,
  input  word_t              ramload,
  output word_t              ramaddr,
  output word_t              ramstore,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [CPUS*32-1:0] iload,
  output logic [CPUS*32-1:0] dload,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS-1:0]    dwait,
  output logic [IDW-1:0]     gnt_id,
  output logic               gnt_vld
);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);

  arb_state_t     state_q, state_d;
  logic [IDW-1:0] gnt_id_q, gnt_id_d;
  logic           gnt_vld_q, gnt_vld_d;
  logic [PW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [BW-1:0]  beat_cnt_q, beat_cnt_d;

  word_t iaddr_w [CPUS];
  word_t daddr_w [CPUS];
  word_t dstore_w [CPUS];
  for (genvar c = 0; c < CPUS; c++) begin : g_unpack
    assign iaddr_w[c]  = iaddr[c*32 +: 32];
    assign daddr_w[c]  = daddr[c*32 +: 32];
    assign dstore_w[c] = dstore[c*32 +: 32];
  end

  logic [PW-1:0] d_idx, i_idx;
  logic          d_vld, i_vld;

  rr_picker #(.N(CPUS), .PW(PW)) u_pick_d (
    .req_i(dREN | dWEN), .ptr_i(rr_ptr_q), .idx_o(d_idx), .vld_o(d_vld)
  );
  rr_picker #(.N(CPUS), .PW(PW)) u_pick_i (
    .req_i(iREN), .ptr_i(rr_ptr_q), .idx_o(i_idx), .vld_o(i_vld)
  );

  // Requester id is {core, class}; class bit 1 means icache.
  logic [IDW-1:0] win_id;
  logic [PW-1:0]  own_core;
  logic           own_is_i, own_wen, own_ren, own_req, own_beat;
  assign win_id   = d_vld ? {d_idx, 1'b0} : {i_idx, 1'b1};
  assign own_core = gnt_id_q[IDW-1:1];
  assign own_is_i = gnt_id_q[0];
  assign own_wen  = !own_is_i && dWEN[own_core];
  assign own_ren  = own_is_i ? iREN[own_core] : (!dWEN[own_core] && dREN[own_core]);
  assign own_req  = own_wen || own_ren;
  assign own_beat = (state_q == GRANT) && own_req && (ramstate == ACCESS);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= IDLE;
      gnt_id_q   <= '0;
      gnt_vld_q  <= 1'b0;
      rr_ptr_q   <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_id_q   <= gnt_id_d;
      gnt_vld_q  <= gnt_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    gnt_id_d   = gnt_id_q;
    gnt_vld_d  = gnt_vld_q;
    rr_ptr_d   = rr_ptr_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      IDLE: begin
        if (d_vld || i_vld) begin
          state_d   = GRANT;
          gnt_id_d  = win_id;
          gnt_vld_d = 1'b1;
        end
      end
      GRANT: begin
        // ERROR and BUSY leave the beat count untouched and keep the lock.
        if (!own_req || (own_beat && beat_cnt_q == LAST_BEAT)) begin
          state_d    = RELEASE;
          gnt_vld_d  = 1'b0;
          beat_cnt_d = '0;
          rr_ptr_d   = (own_core == PW'(CPUS - 1)) ? '0 : own_core + 1'b1;
        end else if (own_beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ramaddr  = '0;
    ramstore = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    iwait    = '1;
    dwait    = '1;
    if (state_q == GRANT) begin
      ramaddr = own_is_i ? iaddr_w[own_core] : daddr_w[own_core];
      ramREN  = own_ren;
      ramWEN  = own_wen;
      if (!own_is_i) ramstore = dstore_w[own_core];
      if (own_beat) begin
        if (own_is_i) iwait[own_core] = 1'b0;
        else          dwait[own_core] = 1'b0;
      end
    end
  end

  assign iload   = {CPUS{ramload}};
  assign dload   = {CPUS{ramload}};
  assign gnt_id  = gnt_id_q;
  assign gnt_vld = gnt_vld_q;
endmodule

// File: tb/tb_ram_bus_arbiter.sv
// tb/tb_ram_bus_arbiter.sv - scoreboard bench for ram_bus_arbiter
module tb_ram_bus_arbiter;
  import cpu_types_pkg::*;
  localparam int CPUS = 2;
  localparam int BURST = 2;
  localparam int NR = 2*CPUS;

  logic CLK = 1'b0;
  logic nRST;
  logic [CPUS-1:0] iREN, dREN, dWEN, iwait, dwait;
  logic [CPUS*32-1:0] iaddr, daddr, dstore, iload, dload;
  ramstate_t ramstate;
  word_t ramload, ramaddr, ramstore;
  logic ramREN, ramWEN, gnt_vld;
  logic [1:0] gnt_id;

  ram_bus_arbiter #(.CPUS(CPUS), .BURST(BURST)) dut (
    .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
    .daddr(daddr), .dstore(dstore), .ramstate(ramstate), .ramload(ramload),
    .ramaddr(ramaddr), .ramstore(ramstore), .ramREN(ramREN), .ramWEN(ramWEN),
    .iload(iload), .dload(dload), .iwait(iwait), .dwait(dwait),
    .gnt_id(gnt_id), .gnt_vld(gnt_vld)
  );

  always #5 CLK = ~CLK;

  typedef struct {int id; logic [31:0] addr; bit wen; logic [31:0] store;} beat_t;
  beat_t exp_q[$];
  int tests = 0, fails = 0;
  bit mon_en = 0;
  int m_ptr = 0;

  bit act[NR], wr[NR], rd[NR], done[NR];
  int need[NR], got[NR];
  logic [31:0] addr[NR], store[NR];

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  function automatic logic wait_of(input int r);
    return (r % 2) ? iwait[r/2] : dwait[r/2];
  endfunction

  task automatic drive_inputs();
    for (int c = 0; c < CPUS; c++) begin
      dWEN[c] = act[2*c] && wr[2*c];
      dREN[c] = act[2*c] && rd[2*c];
      daddr[c*32 +: 32] = addr[2*c];
      dstore[c*32 +: 32] = store[2*c];
      iREN[c] = act[2*c+1];
      iaddr[c*32 +: 32] = addr[2*c+1];
    end
  endtask

  // RAM responder: random latency with occasional ERROR cycles.
  initial begin
    ramstate = FREE;
    ramload = '0;
    forever begin
      int r;
      @(posedge CLK); #1;
      r = $urandom_range(0, 3);
      ramstate = (r < 2) ? ACCESS : (r == 2) ? BUSY : ERROR;
      ramload = $urandom;
    end
  end

  // Scoreboard monitor: every completed ACCESS beat must match the next expected one.
  always @(negedge CLK) begin
    int zeros, zid;
    beat_t e;
    if (mon_en) begin
      zeros = 0; zid = -1;
      for (int c = 0; c < CPUS; c++) begin
        if (!dwait[c]) begin zeros++; zid = 2*c; end
        if (!iwait[c]) begin zeros++; zid = 2*c+1; end
      end
      if (zeros > 1) chk("single_owner_wait", zeros, 1);
      if (gnt_vld && ramstate != ACCESS) chk("wait_outside_access", zeros, 0);
      if (zeros == 1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat_id", zid, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_owner", zid, e.id);
          chk("beat_gnt", {gnt_vld, 30'd0, gnt_id}, {1'b1, 30'd0, 2'(e.id)});
          chk("beat_addr", ramaddr, e.addr);
          chk("beat_en", {ramREN, ramWEN}, {!e.wen, e.wen});
          if (e.wen) chk("beat_store", ramstore, e.store);
          chk("beat_load", (zid % 2) ? iload[(zid/2)*32 +: 32] : dload[(zid/2)*32 +: 32], ramload);
        end
      end
    end
  end

  // Reference model: d class first, round-robin over cores from the pointer,
  // each owner receives its whole transfer before the next is chosen.
  task automatic model_order(input bit [NR-1:0] mask);
    bit pend[NR];
    int pick;
    beat_t b;
    for (int r = 0; r < NR; r++) pend[r] = mask[r];
    forever begin
      pick = -1;
      for (int k = 0; k < CPUS; k++)
        if (pick < 0 && pend[2*((m_ptr+k)%CPUS)]) pick = 2*((m_ptr+k)%CPUS);
      for (int k = 0; k < CPUS; k++)
        if (pick < 0 && pend[2*((m_ptr+k)%CPUS)+1]) pick = 2*((m_ptr+k)%CPUS)+1;
      if (pick < 0) break;
      for (int n = 0; n < need[pick]; n++) begin
        b.id = pick; b.addr = addr[pick];
        b.wen = (pick % 2 == 0) && wr[pick];
        b.store = store[pick];
        exp_q.push_back(b);
      end
      pend[pick] = 0;
      m_ptr = (pick/2 + 1) % CPUS;
    end
  endtask

  task automatic run_scenario(input bit [NR-1:0] mask);
    int cyc;
    bit busy;
    for (int r = 0; r < NR; r++) begin
      act[r] = mask[r]; got[r] = 0; done[r] = 0;
      addr[r] = $urandom; store[r] = $urandom;
      need[r] = $urandom_range(1, BURST);
      wr[r] = (r % 2 == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      rd[r] = wr[r] ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    model_order(mask);
    drive_inputs();
    busy = 1; cyc = 0;
    while (busy && cyc < 300) begin
      @(negedge CLK);
      for (int r = 0; r < NR; r++)
        if (act[r] && !wait_of(r)) begin
          got[r]++;
          if (got[r] >= need[r]) done[r] = 1;
        end
      @(posedge CLK); #1;
      busy = 0;
      for (int r = 0; r < NR; r++) begin
        if (done[r]) begin act[r] = 0; done[r] = 0; end
        busy |= act[r];
      end
      drive_inputs();
      cyc++;
    end
    if (busy) begin
      chk("scenario_timeout", cyc, 0);
      for (int r = 0; r < NR; r++) act[r] = 0;
      drive_inputs();
    end
    repeat (3) @(posedge CLK);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    for (int r = 0; r < NR; r++) begin act[r] = 0; wr[r] = 0; rd[r] = 0; addr[r] = 0; store[r] = 0; end
    drive_inputs();
    nRST = 1'b0;
    repeat (3) @(posedge CLK); #1;
    chk("rst_iwait", iwait, 2'b11);
    chk("rst_dwait", dwait, 2'b11);
    chk("rst_en", {ramREN, ramWEN}, 2'b00);
    chk("rst_gnt", {gnt_vld, gnt_id}, 3'b000);
    chk("rst_bus", ramaddr | ramstore, 32'h0);
    @(negedge CLK); nRST = 1'b1;
    @(posedge CLK); #1; mon_en = 1;

    run_scenario(4'b0110);
    for (int s = 0; s < 30; s++) run_scenario(4'($urandom_range(1, 15)));

    mon_en = 0;
    act[2] = 1; wr[2] = 0; rd[2] = 1; addr[2] = 32'h200;
    drive_inputs();
    cyc = 0;
    @(negedge CLK);
    while (dwait[1] && cyc < 100) begin @(negedge CLK); cyc++; end
    chk("reset_beat_seen", cyc < 100, 1'b1);
    #2 nRST = 1'b0;
    #1;
    chk("async_rst_en", {ramREN, ramWEN}, 2'b00);
    chk("async_rst_gnt", gnt_vld, 1'b0);
    chk("async_rst_dwait", dwait, 2'b11);
    act[2] = 0; drive_inputs();
    @(negedge CLK); nRST = 1'b1;
    m_ptr = 0;
    exp_q.delete();
    @(posedge CLK); #1; mon_en = 1;
    run_scenario(4'b0101);
    run_scenario(4'b1111);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
